// File: rtl/obc1_snes_bus_sync.sv
// rtl/obc1_snes_bus_sync.sv - SNES bus synchroniser, strobe filter and OBC1 window decode
module obc1_snes_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WR_FILTER   = 3,
    parameter int RD_FILTER   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] snes_addr,
    input  logic [7:0]  snes_data,
    input  logic        snes_wr_n,
    input  logic        snes_rd_n,
    output logic        obc_enable,
    output logic [12:0] obc_addr,
    output logic [7:0]  obc_data,
    output logic        obc_we_rising,
    output logic        obc_rd_active
);

    localparam int WCW = (WR_FILTER > 1) ? $clog2(WR_FILTER) : 1;
    localparam int RCW = (RD_FILTER > 1) ? $clog2(RD_FILTER) : 1;
    localparam logic [WCW-1:0] WCNT_MAX = WCW'(WR_FILTER - 1);
    localparam logic [RCW-1:0] RCNT_MAX = RCW'(RD_FILTER - 1);

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WR_LOW = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] rd_sync;
    logic [SYNC_STAGES-1:0] sync_valid;
    logic [16:0]            addr_pipe [SYNC_STAGES];
    logic [7:0]             data_pipe [SYNC_STAGES];

    logic        wr_s;
    logic        rd_s;
    logic        sync_ready;
    logic [16:0] addr_s;
    logic [7:0]  data_s;
    logic        win;
    logic        unused_addr;

    logic [WCW-1:0] wcnt;
    logic [RCW-1:0] rcnt;
    logic [12:0]    hold_addr;
    logic [7:0]     hold_data;
    logic           hold_win;

    logic hold_load;
    logic commit_load;
    logic wr_busy;
    logic rd_accept;

    // Only bit 22 and the low 16 address bits matter to the window and the OBC1 offset.
    assign unused_addr = ^{snes_addr[23], snes_addr[21:16]};

    // sync_valid marks samples that came from the pins rather than from reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync    <= '1;
            rd_sync    <= '1;
            sync_valid <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                addr_pipe[i] <= '0;
                data_pipe[i] <= '0;
            end
        end else begin
            wr_sync[0]    <= snes_wr_n;
            rd_sync[0]    <= snes_rd_n;
            sync_valid[0] <= 1'b1;
            addr_pipe[0]  <= {snes_addr[22], snes_addr[15:0]};
            data_pipe[0]  <= snes_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wr_sync[i]    <= wr_sync[i-1];
                rd_sync[i]    <= rd_sync[i-1];
                sync_valid[i] <= sync_valid[i-1];
                addr_pipe[i]  <= addr_pipe[i-1];
                data_pipe[i]  <= data_pipe[i-1];
            end
        end
    end

    assign wr_s       = wr_sync[SYNC_STAGES-1];
    assign rd_s       = rd_sync[SYNC_STAGES-1];
    assign sync_ready = sync_valid[SYNC_STAGES-1];
    assign addr_s     = addr_pipe[SYNC_STAGES-1];
    assign data_s     = data_pipe[SYNC_STAGES-1];
    assign win        = ~addr_s[16] & (addr_s[15:13] == 3'b011);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ARM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ARM:    if (sync_ready && wr_s) state_next = ST_IDLE;
            ST_IDLE:   if (!wr_s && wcnt == WCNT_MAX) state_next = ST_WR_LOW;
            ST_WR_LOW: if (wr_s) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_ARM;
        endcase
    end

    // The accepting sample is captured too, so a minimum-length write still carries data.
    always_comb begin
        hold_load   = 1'b0;
        commit_load = 1'b0;
        wr_busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                hold_load = (state_next == ST_WR_LOW);
                wr_busy   = (state_next == ST_WR_LOW);
            end
            ST_WR_LOW: begin
                hold_load   = !wr_s;
                commit_load = wr_s;
                wr_busy     = 1'b1;
            end
            ST_COMMIT: wr_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (state != ST_IDLE || wr_s) begin
            wcnt <= '0;
        end else if (wcnt != WCNT_MAX) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_data <= '0;
            hold_win  <= 1'b0;
        end else if (hold_load) begin
            hold_addr <= addr_s[12:0];
            hold_data <= data_s;
            hold_win  <= win;
        end
    end

    // A write accepted on the same edge as a read wins the tie.
    assign rd_accept = !rd_s && (rcnt == RCNT_MAX) && !obc_rd_active && !wr_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt          <= '0;
            obc_rd_active <= 1'b0;
        end else if (wr_busy || rd_s) begin
            rcnt          <= '0;
            obc_rd_active <= 1'b0;
        end else begin
            if (rcnt != RCNT_MAX) begin
                rcnt <= rcnt + 1'b1;
            end
            if (rd_accept) begin
                obc_rd_active <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obc_addr      <= '0;
            obc_data      <= '0;
            obc_enable    <= 1'b0;
            obc_we_rising <= 1'b0;
        end else begin
            obc_we_rising <= commit_load;
            if (commit_load) begin
                obc_addr   <= hold_addr;
                obc_data   <= hold_data;
                obc_enable <= hold_win;
            end else if (rd_accept) begin
                obc_addr   <= addr_s[12:0];
                obc_enable <= win;
            end
        end
    end

endmodule

// File: tb/tb_obc1_snes_bus_sync.sv
// tb/tb_obc1_snes_bus_sync.sv - directed and random checks of obc1_snes_bus_sync against a sample-level model
module tb_obc1_snes_bus_sync;

    localparam int SYNC = 2;
    localparam int WRF  = 3;
    localparam int RDF  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] snes_addr;
    logic [7:0]  snes_data;
    logic        snes_wr_n;
    logic        snes_rd_n;
    logic        obc_enable;
    logic [12:0] obc_addr;
    logic [7:0]  obc_data;
    logic        obc_we_rising;
    logic        obc_rd_active;

    obc1_snes_bus_sync #(
        .SYNC_STAGES(SYNC),
        .WR_FILTER  (WRF),
        .RD_FILTER  (RDF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snes_addr    (snes_addr),
        .snes_data    (snes_data),
        .snes_wr_n    (snes_wr_n),
        .snes_rd_n    (snes_rd_n),
        .obc_enable   (obc_enable),
        .obc_addr     (obc_addr),
        .obc_data     (obc_data),
        .obc_we_rising(obc_we_rising),
        .obc_rd_active(obc_rd_active)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int pulses = 0;
    int rd_hi = 0;
    int last_pulse_edge = 0;
    int rd_rise_edge = 0;
    logic prev_rd = 1'b0;

    // Pin samples still travelling through the synchroniser; index SYNC-1 is the one the logic sees.
    logic        h_wr    [SYNC];
    logic        h_rd    [SYNC];
    logic [23:0] h_addr  [SYNC];
    logic [7:0]  h_data  [SYNC];
    logic        h_valid [SYNC];

    logic        m_armed;
    int          m_wr_run;
    int          m_rd_run;
    logic        m_wr_open;
    logic        m_commit;
    logic [12:0] m_cap_addr;
    logic [7:0]  m_cap_data;
    logic        m_cap_win;
    logic        e_en;
    logic [12:0] e_addr;
    logic [7:0]  e_data;
    logic        e_we;
    logic        e_rd;

    function automatic logic in_window(input logic [23:0] a);
        logic [7:0]  bank;
        logic [15:0] off;
        bank = a[23:16];
        off  = a[15:0];
        return ((bank < 8'h40) || (bank >= 8'h80 && bank < 8'hC0)) &&
               (off >= 16'h6000) && (off <= 16'h7FFF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) begin
            h_wr[i] = 1'b1; h_rd[i] = 1'b1; h_addr[i] = '0; h_data[i] = '0; h_valid[i] = 1'b0;
        end
        m_armed = 1'b0; m_wr_run = 0; m_rd_run = 0; m_wr_open = 1'b0; m_commit = 1'b0;
        m_cap_addr = '0; m_cap_data = '0; m_cap_win = 1'b0;
        e_en = 1'b0; e_addr = '0; e_data = '0; e_we = 1'b0; e_rd = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic r, input logic [23:0] a,
                              input logic [7:0] d, input logic valid);
        logic busy_pre;
        logic wr_acc;
        busy_pre = m_wr_open || m_commit;
        wr_acc   = 1'b0;
        e_we     = 1'b0;
        if (m_commit) begin
            m_commit = 1'b0;
            m_wr_run = 0;
        end else if (!m_armed) begin
            if (valid && w) m_armed = 1'b1;
        end else if (m_wr_open) begin
            if (!w) begin
                m_cap_addr = a[12:0]; m_cap_data = d; m_cap_win = in_window(a);
            end else begin
                m_wr_open = 1'b0;
                m_commit  = 1'b1;
                e_we = 1'b1; e_addr = m_cap_addr; e_data = m_cap_data; e_en = m_cap_win;
            end
        end else if (!w) begin
            m_wr_run++;
            if (m_wr_run >= WRF) begin
                m_wr_open = 1'b1;
                wr_acc    = 1'b1;
                m_cap_addr = a[12:0]; m_cap_data = d; m_cap_win = in_window(a);
            end
        end else begin
            m_wr_run = 0;
        end
        if (busy_pre || wr_acc || r) begin
            m_rd_run = 0;
            e_rd = 1'b0;
        end else begin
            m_rd_run++;
            if (m_rd_run >= RDF && !e_rd) begin
                e_rd = 1'b1; e_addr = a[12:0]; e_en = in_window(a);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive pins, advance one clock, update the model, compare at the next negedge.
    task automatic cyc(input logic w, input logic r, input logic [23:0] a, input logic [7:0] d);
        snes_wr_n = w; snes_rd_n = r; snes_addr = a; snes_data = d;
        @(posedge clk);
        if (rst_n) begin
            cyc_n++;
            model_edge(h_wr[SYNC-1], h_rd[SYNC-1], h_addr[SYNC-1], h_data[SYNC-1], h_valid[SYNC-1]);
            for (int i = SYNC - 1; i > 0; i--) begin
                h_wr[i] = h_wr[i-1]; h_rd[i] = h_rd[i-1]; h_addr[i] = h_addr[i-1];
                h_data[i] = h_data[i-1]; h_valid[i] = h_valid[i-1];
            end
            h_wr[0] = w; h_rd[0] = r; h_addr[0] = a; h_data[0] = d; h_valid[0] = 1'b1;
        end
        @(negedge clk);
        vectors++;
        assert ({obc_enable, obc_addr, obc_data, obc_we_rising, obc_rd_active} ===
                {e_en, e_addr, e_data, e_we, e_rd}) else begin
            miscompares++;
            $error("FAIL outputs edge %0d observed=%h expected=%h", cyc_n,
                   {obc_enable, obc_addr, obc_data, obc_we_rising, obc_rd_active},
                   {e_en, e_addr, e_data, e_we, e_rd});
        end
        if (obc_we_rising) begin
            pulses++;
            last_pulse_edge = cyc_n;
        end
        if (obc_rd_active) rd_hi++;
        if (obc_rd_active && !prev_rd) rd_rise_edge = cyc_n;
        prev_rd = obc_rd_active;
    endtask

    task automatic do_reset(input logic w);
        rst_n = 1'b0;
        model_reset();
        cyc(w, 1'b1, snes_addr, snes_data);
        chk("reset_outputs", {17'd0, obc_enable, obc_addr, obc_data, obc_we_rising, obc_rd_active}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wr_txn(input logic [23:0] a, input logic [7:0] d, input int len, input int gap);
        for (int i = 0; i < len; i++) cyc(1'b0, 1'b1, a, d);
        for (int i = 0; i < gap; i++) cyc(1'b1, 1'b1, a, d);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int p0;
        int r0;
        int rise_edge;
        int fall_edge;
        snes_wr_n = 1'b1; snes_rd_n = 1'b1; snes_addr = '0; snes_data = '0; rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 24'h000000, 8'h00);

        // Full write inside the window, with release-to-pulse latency.
        p0 = pulses;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 24'h007FF0, 8'h5A);
        rise_edge = cyc_n + 1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 24'h007FF0, 8'h5A);
        chk("t1_pulses", pulses - p0, 1);
        chk("t1_latency", last_pulse_edge - rise_edge + 1, SYNC + 1);
        chk("t1_addr", obc_addr, 13'h1FF0);
        chk("t1_data", obc_data, 8'h5A);
        chk("t1_enable", obc_enable, 1'b1);

        // Two-sample glitch is rejected and leaves outputs alone.
        p0 = pulses;
        wr_txn(24'h007FF0, 8'hC3, 2, 6);
        chk("t2_pulses", pulses - p0, 0);
        chk("t2_addr", obc_addr, 13'h1FF0);
        chk("t2_data", obc_data, 8'h5A);

        // Bank $40 is outside the window.
        p0 = pulses;
        wr_txn(24'h407000, 8'h11, 6, 6);
        chk("t3_pulses", pulses - p0, 1);
        chk("t3_enable", obc_enable, 1'b0);
        chk("t3_addr", obc_addr, 13'h1000);
        chk("t3_data", obc_data, 8'h11);

        // Reset released while /WR is low: that write is dropped, the next one works.
        p0 = pulses;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 24'h007FF0, 8'hAA);
        do_reset(1'b0);
        wr_txn(24'h007FF0, 8'hAA, 6, 6);
        chk("t4_dropped", pulses - p0, 0);
        p0 = pulses;
        wr_txn(24'h006123, 8'h77, 5, 6);
        chk("t4_next_pulses", pulses - p0, 1);
        chk("t4_next_addr", obc_addr, 13'h0123);

        // Data changing mid-write: last sample wins.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 24'h007001, 8'h22);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 24'h007001, 8'h33);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 24'h007001, 8'h99);
        chk("t5_data", obc_data, 8'h33);

        // Read in bank $80, then read and write together.
        fall_edge = cyc_n + 1;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 24'h807C00, 8'h00);
        chk("t6_rd_latency", rd_rise_edge - fall_edge + 1, SYNC + RDF);
        chk("t6_rd_active", obc_rd_active, 1'b1);
        chk("t6_addr", obc_addr, 13'h1C00);
        chk("t6_enable", obc_enable, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 24'h807C00, 8'h00);
        chk("t6_rd_cleared", obc_rd_active, 1'b0);
        p0 = pulses;
        r0 = rd_hi;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 24'h006044, 8'h44);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 24'h006044, 8'h44);
        chk("t6_rd_blocked", rd_hi - r0, 0);
        chk("t6_wr_pulses", pulses - p0, 1);
        chk("t6_wr_addr", obc_addr, 13'h0044);

        // Reset mid-write drops the pending commit.
        p0 = pulses;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 24'h007123, 8'h5E);
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 24'h007123, 8'h5E);
        chk("t7_dropped", pulses - p0, 0);

        // Random traffic, checked every cycle against the model.
        for (int t = 0; t < 120; t++) begin
            int kind;
            int len;
            int gap;
            logic [23:0] a;
            kind = $urandom_range(0, 4);
            len  = $urandom_range(1, 9);
            gap  = $urandom_range(5, 9);
            a    = 24'($urandom);
            if ($urandom_range(0, 1) == 1) a[15:13] = 3'b011;
            for (int i = 0; i < len; i++) begin
                case (kind)
                    0, 1:    cyc(1'b0, 1'b1, a, 8'($urandom));
                    2:       cyc(1'b1, 1'b0, a, 8'($urandom));
                    3:       cyc(1'b0, 1'b0, a, 8'($urandom));
                    default: cyc(1'b0, 1'($urandom), a, 8'($urandom));
                endcase
            end
            if (kind == 4) do_reset(1'($urandom));
            for (int i = 0; i < gap; i++) cyc(1'b1, 1'b1, 24'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
